bcd_opg_sequencer: RTL and testbench
====================================

// Module: bcd_opg_sequencer
// PURPOSE
//  Feeds BCD digits to the serial BCD odd-parity generator (OPG) one bit per clock.
//  Each digit is accepted on a valid/ready handshake, range-checked and shifted out on x_out.
//  The OPG is held in reset between digits, so every digit starts a fresh 4-bit frame.
//  The OPG's Mealy output z is captured on the last bit and checked against an internally
//  computed odd-parity bit. Result is reported upstream.
// PARAMETERS
//  MSB_FIRST   0   0: bit order d0..d3; 1: d3..d0
//  GAP_CYCLES  0   extra idle cycles (OPG held in reset) after each digit, 0..15
//  COUNT_W     8   width of digit_count
//  ERR_STICKY  1   1: mismatch holds until reset; 0: mismatch valid with out_valid only
// PORTS
//  clock        in   1        rising-edge clock
//  reset        in   1        asynchronous, active-high
//  in_valid     in   1        upstream digit valid
//  in_digit     in   4        BCD digit
//  in_ready     out  1        sequencer can accept a digit this cycle
//  x_out        out  1        serial bit to OPG x input
//  opg_rst_n    out  1        OPG reset, active-low, registered
//  z_in         in   1        OPG z output (Mealy, valid during 4th bit)
//  out_valid    out  1        1-cycle pulse: digit result available
//  out_digit    out  4        digit just completed
//  out_parity   out  1        z_in captured on 4th bit
//  mismatch     out  1        captured z_in != ~^digit
//  bcd_err      out  1        1-cycle pulse: rejected digit (>9)
//  digit_count  out  COUNT_W  completed digits, wraps to 0
// BEHAVIOUR
//  Reset (async, immediate) sets:
//   - state=IDLE; in_ready=1; x_out=0; opg_rst_n=0
//   - out_valid=0; out_digit=0; out_parity=0; mismatch=0; bcd_err=0; digit_count=0
//  States: IDLE, SHIFT, GAP.
//  IDLE:
//   - in_ready=1, x_out=0, opg_rst_n=0.
//   - in_valid&&in_digit<=9: at the edge, latch digit into shift reg, set bit_idx=0,
//     set opg_rst_n=1 and go to SHIFT.
//   - in_valid&&in_digit>9: digit dropped; bcd_err=1 for the next cycle; stay IDLE.
//  SHIFT:
//   - in_ready=0; x_out = current bit, taken from the register.
//   - bit_idx 0..3, +1 per clock.
//   - At bit_idx==3:
//     - sample z_in.
//     - next cycle: out_valid=1; out_digit=digit; out_parity=z_in;
//       mismatch = z_in ^ ~(^digit); digit_count+1 (wrapping).
//     - opg_rst_n=0.
//     - go to GAP if GAP_CYCLES>0, else to IDLE.
//  GAP: in_ready=0, x_out=0, opg_rst_n=0; stay GAP_CYCLES cycles, then go to IDLE.
//  Timing:
//   - Accept edge -> first bit on x_out: same edge (0 extra cycles).
//   - Last bit -> out_valid: 1 cycle.
//   - Throughput: 1 digit per 5+GAP_CYCLES cycles; in_valid held high is accepted again
//     on the first IDLE cycle.
//  ERR_STICKY=1: mismatch is only set (never cleared by later good digits); cleared only by reset.
//  ERR_STICKY=0: mismatch is updated only on out_valid cycles.
//  Reset mid-SHIFT: the digit is discarded, no out_valid, and the OPG is reset at once
//  via opg_rst_n=0.
//  in_digit changes while in SHIFT/GAP: ignored (the digit is latched at accept).
// TESTING
//  1. MSB_FIRST=0, digit 5 -> x_out 1,0,1,0; z_in=1 -> out_valid, out_parity=1, mismatch=0, digit_count=1.
//  2. Digit 7 then 0, in_valid held, GAP=0 -> accepts 5 cycles apart; parity 0 then 1; count=2.
//  3. Digit 12 -> bcd_err pulse, in_ready stays 1, opg_rst_n stays 0, no out_valid, count unchanged.
//  4. Digit 9, z_in forced 1 (expected 1) then digit 3, z_in forced 1 (expected 1)
//     then digit 1, z_in 1 (expected 0) -> mismatch=1.
//     ERR_STICKY=1: mismatch remains 1 after a subsequent good digit.
//  5. reset pulse at bit_idx==2 -> all outputs at reset values immediately; next digit 4 completes normally.
//  6. COUNT_W=2, GAP_CYCLES=2, 5 digits -> digit_count wraps to 1; spacing 7 cycles; MSB_FIRST=1 digit 8 -> x_out 1,0,0,0.

Source files
------------

// File: rtl/bcd_opg_sequencer.sv
// Accepts BCD digits over valid/ready and serialises each into a fresh 4-bit OPG frame.
// First bit is on x_out right after the accept edge; the result follows the last bit by 1 cycle.
`timescale 1ns/1ps
module bcd_opg_sequencer #(
  parameter bit MSB_FIRST  = 1'b0,
  parameter int GAP_CYCLES = 0,
  parameter int COUNT_W    = 8,
  parameter bit ERR_STICKY = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [3:0]         in_digit,
  output logic               in_ready,
  output logic               x_out,
  output logic               opg_rst_n,
  input  logic               z_in,
  output logic               out_valid,
  output logic [3:0]         out_digit,
  output logic               out_parity,
  output logic               mismatch,
  output logic               bcd_err,
  output logic [COUNT_W-1:0] digit_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  localparam logic [3:0] GAP_LAST = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

  logic [1:0] state;
  logic [3:0] shreg;
  logic [1:0] bit_idx;
  logic [1:0] bit_pos;
  logic [3:0] gap_cnt;
  logic       exp_parity;
  logic       cur_mismatch;

  // MSB-first walks the register from bit 3 down; ~bit_idx == 3 - bit_idx for 2 bits.
  assign bit_pos      = MSB_FIRST ? ~bit_idx : bit_idx;
  assign in_ready     = (state == S_IDLE);
  assign x_out        = (state == S_SHIFT) ? shreg[bit_pos] : 1'b0;
  assign exp_parity   = ~(^shreg);
  assign cur_mismatch = z_in ^ exp_parity;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      shreg       <= 4'd0;
      bit_idx     <= 2'd0;
      gap_cnt     <= 4'd0;
      opg_rst_n   <= 1'b0;
      out_valid   <= 1'b0;
      out_digit   <= 4'd0;
      out_parity  <= 1'b0;
      mismatch    <= 1'b0;
      bcd_err     <= 1'b0;
      digit_count <= '0;
    end else begin
      out_valid <= 1'b0;
      bcd_err   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            if (in_digit <= 4'd9) begin
              shreg     <= in_digit;
              bit_idx   <= 2'd0;
              opg_rst_n <= 1'b1;
              state     <= S_SHIFT;
            end else begin
              bcd_err <= 1'b1;
            end
          end
        end
        S_SHIFT: begin
          if (bit_idx == 2'd3) begin
            out_valid   <= 1'b1;
            out_digit   <= shreg;
            out_parity  <= z_in;
            mismatch    <= ERR_STICKY ? (mismatch | cur_mismatch) : cur_mismatch;
            digit_count <= digit_count + {{(COUNT_W-1){1'b0}}, 1'b1};
            opg_rst_n   <= 1'b0;
            gap_cnt     <= 4'd0;
            state       <= (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
          end else begin
            bit_idx <= bit_idx + 2'd1;
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_opg_sequencer.sv
// Directed plus randomised bench for two sequencer configurations; the bench plays the OPG via z_in.
`timescale 1ns/1ps
module tb_bcd_opg_sequencer;

  logic       clk = 1'b0;
  logic       rst [2];
  logic       iv  [2];
  logic [3:0] id  [2];
  logic       z   [2];
  logic       ir  [2];
  logic       xo  [2];
  logic       orn [2];
  logic       ov  [2];
  logic [3:0] od  [2];
  logic       op  [2];
  logic       mm  [2];
  logic       be  [2];
  logic [7:0] cnt [2];
  logic [7:0] dc0;
  logic [1:0] dc1;

  int checks = 0;
  int errors = 0;

  // Per-instance configuration and reference state.
  int gap    [2] = '{0, 2};
  int msb    [2] = '{0, 1};
  int cw     [2] = '{8, 2};
  bit sticky [2] = '{1'b1, 1'b0};
  int exp_cnt[2] = '{0, 0};
  bit exp_mis[2] = '{1'b0, 1'b0};

  always #5 clk = ~clk;

  bcd_opg_sequencer #(.MSB_FIRST(1'b0), .GAP_CYCLES(0), .COUNT_W(8), .ERR_STICKY(1'b1)) dut0 (
    .clock(clk), .reset(rst[0]), .in_valid(iv[0]), .in_digit(id[0]), .in_ready(ir[0]),
    .x_out(xo[0]), .opg_rst_n(orn[0]), .z_in(z[0]), .out_valid(ov[0]), .out_digit(od[0]),
    .out_parity(op[0]), .mismatch(mm[0]), .bcd_err(be[0]), .digit_count(dc0));

  bcd_opg_sequencer #(.MSB_FIRST(1'b1), .GAP_CYCLES(2), .COUNT_W(2), .ERR_STICKY(1'b0)) dut1 (
    .clock(clk), .reset(rst[1]), .in_valid(iv[1]), .in_digit(id[1]), .in_ready(ir[1]),
    .x_out(xo[1]), .opg_rst_n(orn[1]), .z_in(z[1]), .out_valid(ov[1]), .out_digit(od[1]),
    .out_parity(op[1]), .mismatch(mm[1]), .bcd_err(be[1]), .digit_count(dc1));

  assign cnt[0] = dc0;
  assign cnt[1] = {6'd0, dc1};

  function automatic bit odd_par(input logic [3:0] d);
    return ($countones(d) % 2) == 0;
  endfunction

  function automatic logic exp_bit(input int i, input logic [3:0] d, input int b);
    int pos;
    pos = (msb[i] != 0) ? 3 - b : b;
    return logic'((d >> pos) & 4'd1);
  endfunction

  task automatic chk(input string tag, input int i, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, i, obs, exp_v);
    end
  endtask

  task automatic chk_reset_vals(input int i);
    chk("rst_in_ready", i, 8'(ir[i]), 8'd1);
    chk("rst_x_out", i, 8'(xo[i]), 8'd0);
    chk("rst_opg_rst_n", i, 8'(orn[i]), 8'd0);
    chk("rst_out_valid", i, 8'(ov[i]), 8'd0);
    chk("rst_out_digit", i, 8'(od[i]), 8'd0);
    chk("rst_out_parity", i, 8'(op[i]), 8'd0);
    chk("rst_mismatch", i, 8'(mm[i]), 8'd0);
    chk("rst_bcd_err", i, 8'(be[i]), 8'd0);
    chk("rst_count", i, cnt[i], 8'd0);
  endtask

  // Called at a negedge with instance i idle; returns at the negedge of its next idle cycle.
  task automatic run_digit(input int i, input logic [3:0] d, input logic zv, input bit hold);
    bit mmv;
    iv[i] = 1'b1;
    id[i] = d;
    chk("accept_ready", i, 8'(ir[i]), 8'd1);
    @(posedge clk);
    @(negedge clk);
    if (!hold) iv[i] = 1'b0;
    id[i] = 4'($urandom_range(0, 15));
    for (int b = 0; b < 4; b++) begin
      chk("x_out_bit", i, 8'(xo[i]), 8'(exp_bit(i, d, b)));
      chk("shift_opg_rst_n", i, 8'(orn[i]), 8'd1);
      chk("shift_in_ready", i, 8'(ir[i]), 8'd0);
      if (b == 3) z[i] = zv;
      @(negedge clk);
    end
    mmv = zv ^ odd_par(d);
    exp_mis[i] = sticky[i] ? (exp_mis[i] | mmv) : mmv;
    exp_cnt[i] = (exp_cnt[i] + 1) % (1 << cw[i]);
    chk("out_valid", i, 8'(ov[i]), 8'd1);
    chk("out_digit", i, 8'(od[i]), 8'(d));
    chk("out_parity", i, 8'(op[i]), 8'(zv));
    chk("mismatch", i, 8'(mm[i]), 8'(exp_mis[i]));
    chk("digit_count", i, cnt[i], 8'(exp_cnt[i]));
    chk("done_opg_rst_n", i, 8'(orn[i]), 8'd0);
    chk("done_in_ready", i, 8'(ir[i]), 8'(gap[i] == 0));
    for (int g = 1; g < gap[i]; g++) begin
      @(negedge clk);
      chk("gap_in_ready", i, 8'(ir[i]), 8'd0);
      chk("gap_out_valid", i, 8'(ov[i]), 8'd0);
      chk("gap_x_out", i, 8'(xo[i]), 8'd0);
    end
    if (gap[i] > 0) @(negedge clk);
  endtask

  task automatic reject(input int i, input logic [3:0] d);
    iv[i] = 1'b1;
    id[i] = d;
    chk("rej_ready", i, 8'(ir[i]), 8'd1);
    @(negedge clk);
    iv[i] = 1'b0;
    chk("rej_bcd_err", i, 8'(be[i]), 8'd1);
    chk("rej_in_ready", i, 8'(ir[i]), 8'd1);
    chk("rej_opg_rst_n", i, 8'(orn[i]), 8'd0);
    chk("rej_out_valid", i, 8'(ov[i]), 8'd0);
    chk("rej_count", i, cnt[i], 8'(exp_cnt[i]));
    chk("rej_mismatch", i, 8'(mm[i]), 8'(exp_mis[i]));
    @(negedge clk);
    chk("rej_bcd_err_clr", i, 8'(be[i]), 8'd0);
  endtask

  initial begin
    logic [3:0] d;
    int         k;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; iv[i] = 1'b0; id[i] = 4'd0; z[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    chk_reset_vals(0);
    chk_reset_vals(1);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge clk);

    // Basic LSB-first digit, then back-to-back digits with in_valid held.
    run_digit(0, 4'd5, 1'b1, 1'b0);
    run_digit(0, 4'd7, 1'b0, 1'b1);
    run_digit(0, 4'd0, 1'b1, 1'b0);
    reject(0, 4'd12);

    // Forced parity errors: sticky on instance 0.
    run_digit(0, 4'd9, 1'b1, 1'b0);
    run_digit(0, 4'd3, 1'b1, 1'b0);
    run_digit(0, 4'd1, 1'b1, 1'b0);
    chk("sticky_set", 0, 8'(mm[0]), 8'd1);
    run_digit(0, 4'd2, odd_par(4'd2), 1'b0);
    chk("sticky_hold", 0, 8'(mm[0]), 8'd1);

    // Reset in the middle of a frame (third bit on the wire).
    iv[0] = 1'b1;
    id[0] = 4'd6;
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst[0] = 1'b1;
    #1;
    exp_cnt[0] = 0;
    exp_mis[0] = 1'b0;
    chk_reset_vals(0);
    @(negedge clk);
    rst[0] = 1'b0;
    @(negedge clk);
    chk("post_rst_out_valid", 0, 8'(ov[0]), 8'd0);
    run_digit(0, 4'd4, odd_par(4'd4), 1'b0);

    // MSB-first, gapped, 2-bit counter: five digits wrap the count to 1.
    run_digit(1, 4'd3, 1'b1, 1'b1);
    run_digit(1, 4'd1, 1'b0, 1'b1);
    run_digit(1, 4'd2, 1'b0, 1'b1);
    run_digit(1, 4'd7, 1'b0, 1'b1);
    run_digit(1, 4'd8, 1'b0, 1'b0);
    chk("wrap_count", 1, cnt[1], 8'd1);
    reject(1, 4'd15);

    // Non-sticky: mismatch follows the latest digit.
    run_digit(1, 4'd1, 1'b1, 1'b0);
    chk("nonsticky_set", 1, 8'(mm[1]), 8'd1);
    run_digit(1, 4'd6, 1'b1, 1'b0);
    chk("nonsticky_clr", 1, 8'(mm[1]), 8'd0);

    // Random digits and random OPG responses on both instances.
    for (int n = 0; n < 40; n++) begin
      k = n % 2;
      d = 4'($urandom_range(0, 15));
      if (d > 4'd9) reject(k, d);
      else run_digit(k, d, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
